// File: rtl/bcd_scan_ctrl_if.sv
// rtl/bcd_scan_ctrl_if.sv - load handshake and decoder-side display bus of bcd_scan_ctrl
interface bcd_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  load_valid;
  logic                  load_ready;
  logic [4*DIGITS-1:0]   load_data;
  logic [3:0]            bcd_out;
  logic [DIGITS-1:0]     digit_sel;
  logic                  blank;
  logic                  frame_done;
  logic                  bad_digit;

  modport master (
    output load_valid, load_data,
    input  load_ready, bcd_out, digit_sel, blank, frame_done, bad_digit
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, bcd_out, digit_sel, blank, frame_done, bad_digit
  );
endinterface

// File: rtl/bcd_scan_ctrl.sv
// rtl/bcd_scan_ctrl.sv - time-multiplexed BCD digit scanner with one-entry pending buffer
// New words swap into the active frame only at frame boundaries so a frame is never torn.
module bcd_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DWELL  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  bcd_scan_ctrl_if.slave bus
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int W  = 4 * DIGITS;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      pending_q, pending_d;
  logic              pending_full_q, pending_full_d;
  logic [W-1:0]      active_q, active_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic [3:0]        bcd_q, bcd_d;
  logic              blank_q, blank_d;
  logic              bad_q, bad_d;

  logic              last_dwell;
  logic              frame_end;
  logic              accept;
  logic              swap;
  logic [3:0]        code;

  always_comb begin
    last_dwell = (dwell_q == DW'(DWELL - 1));
    frame_end  = (state_q == SCAN) && (idx_q == IW'(DIGITS - 1)) && last_dwell;
    accept     = bus.load_valid && !pending_full_q;
    // accept needs an empty buffer and swap a full one, so they never coincide
    swap       = pending_full_q && ((state_q == IDLE) || frame_end);

    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    active_d       = active_q;
    state_d        = state_q;
    idx_d          = idx_q;
    dwell_d        = dwell_q;

    if (accept) begin
      pending_d      = bus.load_data;
      pending_full_d = 1'b1;
    end else if (swap) begin
      pending_full_d = 1'b0;
    end

    if (swap) begin
      active_d = pending_q;
    end

    case (state_q)
      IDLE: begin
        if (pending_full_q) begin
          state_d = SCAN;
          idx_d   = '0;
          dwell_d = '0;
        end
      end
      SCAN: begin
        if (last_dwell) begin
          dwell_d = '0;
          idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // outputs are registered from next-state values so they line up with idx/dwell
    code        = 4'(active_d >> {idx_d, 2'b00});
    digit_sel_d = '0;
    bcd_d       = 4'd0;
    blank_d     = 1'b1;
    bad_d       = bad_q;
    if (state_d == SCAN) begin
      digit_sel_d = DIGITS'(1) << idx_d;
      if (code <= 4'd9) begin
        bcd_d   = code;
        blank_d = 1'b0;
      end else begin
        bad_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      active_q       <= '0;
      idx_q          <= '0;
      dwell_q        <= '0;
      digit_sel_q    <= '0;
      bcd_q          <= 4'd0;
      blank_q        <= 1'b1;
      bad_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      active_q       <= active_d;
      idx_q          <= idx_d;
      dwell_q        <= dwell_d;
      digit_sel_q    <= digit_sel_d;
      bcd_q          <= bcd_d;
      blank_q        <= blank_d;
      bad_q          <= bad_d;
    end
  end

  assign bus.load_ready = !pending_full_q;
  assign bus.frame_done = frame_end;
  assign bus.digit_sel  = digit_sel_q;
  assign bus.bcd_out    = bcd_q;
  assign bus.blank      = blank_q;
  assign bus.bad_digit  = bad_q;
endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// tb/tb_bcd_scan_ctrl.sv - directed bench for bcd_scan_ctrl (4x4 instance and 2-digit DWELL=1 instance)
module tb_bcd_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   bad_m   = 1'b0;

  always #5 clk = ~clk;

  bcd_scan_ctrl_if #(.DIGITS(4)) a ();
  bcd_scan_ctrl_if #(.DIGITS(2)) b ();

  bcd_scan_ctrl #(.DIGITS(4), .DWELL(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  bcd_scan_ctrl #(.DIGITS(2), .DWELL(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".sel"},   32'(a.digit_sel), 32'h0);
    chk({tag, ".bcd"},   32'(a.bcd_out),   32'h0);
    chk({tag, ".blank"}, 32'(a.blank),     32'h1);
    chk({tag, ".fd"},    32'(a.frame_done), 32'h0);
  endtask

  // Checks one 16-cycle frame of the 4x4 instance starting at its first cycle.
  // load_ready is expected high for cycles below rdy_lim; a word is offered at cycle load_c.
  task automatic check_frame(input string tag, input logic [15:0] w, input int rdy_lim,
                             input int load_c, input logic [15:0] load_w);
    logic [15:0] sh;
    logic [3:0]  code;
    bit          acc;
    for (int c = 0; c < 16; c++) begin
      sh   = w >> (4 * (c / 4));
      code = sh[3:0];
      if (code > 4'd9) bad_m = 1'b1;
      chk($sformatf("%s.c%0d.sel", tag, c),   32'(a.digit_sel),  32'(4'b0001 << (c / 4)));
      chk($sformatf("%s.c%0d.bcd", tag, c),   32'(a.bcd_out),    (code > 4'd9) ? 32'h0 : 32'(code));
      chk($sformatf("%s.c%0d.blank", tag, c), 32'(a.blank),      32'(code > 4'd9));
      chk($sformatf("%s.c%0d.fd", tag, c),    32'(a.frame_done), 32'(c == 15));
      chk($sformatf("%s.c%0d.bad", tag, c),   32'(a.bad_digit),  32'(bad_m));
      chk($sformatf("%s.c%0d.rdy", tag, c),   32'(a.load_ready), 32'(c < rdy_lim));
      if (c == load_c) begin
        a.load_valid = 1'b1;
        a.load_data  = load_w;
      end
      acc = a.load_valid && a.load_ready;
      tick();
      if (acc) a.load_valid = 1'b0;
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    a.load_valid = 1'b0;
    a.load_data  = '0;
    b.load_valid = 1'b0;
    b.load_data  = '0;
    tick();
    tick();
    rst_n = 1'b1;
    chk_idle("rst");
    chk("rst.rdy", 32'(a.load_ready), 32'h1);
    chk("rst.bad", 32'(a.bad_digit),  32'h0);

    // scan order and repeat
    a.load_valid = 1'b1;
    a.load_data  = 16'h4219;
    tick();
    a.load_valid = 1'b0;
    chk("lat0.rdy", 32'(a.load_ready), 32'h0);
    chk_idle("lat0");
    tick();
    check_frame("scan0", 16'h4219, 16, -1, 16'h0);
    check_frame("scan1", 16'h4219, 16, -1, 16'h0);

    // buffering from a fresh idle state
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk_idle("rst2");
    a.load_valid = 1'b1;
    a.load_data  = 16'h1111;
    tick();
    chk("buf0.rdy", 32'(a.load_ready), 32'h0);
    a.load_data = 16'h2222;
    tick();
    check_frame("buf1", 16'h1111, 1, -1, 16'h0);
    a.load_valid = 1'b1;
    a.load_data  = 16'h3333;
    check_frame("buf2", 16'h2222, 1, -1, 16'h0);
    // offer 0x5555 exactly in the frame_done cycle with pending empty
    check_frame("buf3", 16'h3333, 16, 15, 16'h5555);
    check_frame("col1", 16'h3333, 0, -1, 16'h0);
    check_frame("col2", 16'h5555, 16, -1, 16'h0);

    // invalid code and sticky bad_digit
    a.load_valid = 1'b1;
    a.load_data  = 16'h0A30;
    check_frame("col3", 16'h5555, 1, -1, 16'h0);
    a.load_valid = 1'b1;
    a.load_data  = 16'h0000;
    check_frame("inv", 16'h0A30, 1, -1, 16'h0);
    check_frame("zero", 16'h0000, 16, -1, 16'h0);

    // mid-scan reset discards a pending word
    a.load_valid = 1'b1;
    a.load_data  = 16'h7777;
    tick();
    a.load_valid = 1'b0;
    chk("pre.rdy", 32'(a.load_ready), 32'h0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    bad_m = 1'b0;
    chk_idle("rst3");
    chk("rst3.rdy", 32'(a.load_ready), 32'h1);
    chk("rst3.bad", 32'(a.bad_digit),  32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle($sformatf("idle%0d", i));
    end
    a.load_valid = 1'b1;
    a.load_data  = 16'h9876;
    tick();
    a.load_valid = 1'b0;
    chk_idle("nobypass");
    tick();
    check_frame("lat", 16'h9876, 16, -1, 16'h0);

    // DWELL=1, DIGITS=2 instance
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("b.rst.sel", 32'(b.digit_sel), 32'h0);
    b.load_valid = 1'b1;
    b.load_data  = 8'h87;
    tick();
    b.load_valid = 1'b0;
    tick();
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("b.c%0d.sel", c),   32'(b.digit_sel),  (c % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("b.c%0d.bcd", c),   32'(b.bcd_out),    (c % 2 == 0) ? 32'h7 : 32'h8);
      chk($sformatf("b.c%0d.blank", c), 32'(b.blank),      32'h0);
      chk($sformatf("b.c%0d.fd", c),    32'(b.frame_done), 32'(c % 2 == 1));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
